ahb_sram_bridge: RTL and testbench
==================================

# ahb_sram_bridge

AHB-Lite slave front-end placed directly upstream of the on-chip SRAM macro. It converts zero-wait-state AHB transfers into the SRAM's byte-enabled write / registered-address read port. AHB write data arrives one cycle after its address, while an SRAM read must be issued in its own address phase. To resolve this, the bridge holds a one-entry write buffer that drains on idle port cycles, and it forwards buffered bytes into read data on an address hit.

## Interface
- `AW`, 16, SRAM word-address width (SRAM holds 2^AW 32-bit words)
- `HCLK` in 1: single clock for the bridge and the SRAM
- `HRESETn` in 1: asynchronous, active-low reset
- `HSEL` in 1: slave select
- `HREADY` in 1: bus-level ready
- `HTRANS` in 2: transfer type (`HTRANS[1]` = NONSEQ/SEQ)
- `HSIZE` in 3: 0 byte, 1 half, ≥2 word
- `HWRITE` in 1: 1 = write
- `HADDR` in 32: byte address, bits [AW+1:2] used
- `HWDATA` in 32: write data, valid in data phase
- `HREADYOUT` out 1: constant 1
- `HRESP` out 1: constant 0 (OKAY)
- `HRDATA` out 32: read data, in the read data phase
- `SRAMRDATA` in 32: SRAM read data, valid the cycle after a read `SRAMCS`
- `SRAMADDR` out AW: SRAM word address
- `SRAMWDATA` out 32: SRAM write data
- `SRAMWEN` out 4: byte write enables
- `SRAMCS` out 1: SRAM chip select

## Operation
- Transfer valid: `trans_ok = HSEL & HREADY & HTRANS[1]`.
  - `rd_req = trans_ok & ~HWRITE`
  - `wr_req = trans_ok & HWRITE`
- Byte mask comes from `HSIZE` and `HADDR[1:0]`:
  - byte: lane `HADDR[1:0]`
  - half: lanes {1,0} if `HADDR[1]=0`, else {3,2}
  - word: 4'b1111
  - Misaligned low bits are ignored, with no error.
- State registers: `wph` (a write data phase is active this cycle), `buf_addr[AW-1:0]`, `buf_mask[3:0]`, `buf_data[31:0]`, `buf_pend`, `rd_hit_mask[3:0]`.
- On `wr_req`: `wph`←1 next cycle, `buf_addr`←`HADDR[AW+1:2]`, `buf_mask`←mask.
- SRAM port priority each cycle:
  1. `rd_req`: `SRAMADDR`=`HADDR[AW+1:2]`, `SRAMCS`=1, `SRAMWEN`=0.
  2. else `wph`: write `buf_addr`/`buf_mask` with live `HWDATA`, `SRAMCS`=1.
  3. else `buf_pend`: write `buf_addr`/`buf_mask`/`buf_data`, `SRAMCS`=1, `buf_pend`←0.
  4. else `SRAMCS`=0, `SRAMWEN`=0, and `SRAMADDR`/`SRAMWDATA` hold their previous value.
- `wph & rd_req`: the write is deferred. `buf_data`←`HWDATA` and `buf_pend`←1.
- Invariant: `wph` and `buf_pend` are never both 1. Any cycle between the deferral and the next `wph` is either a read data phase or idle, and the deferred write drains there.
- Read hazard check, during the read address phase:
  - hit if (`wph` | `buf_pend`) and `HADDR[AW+1:2]`==`buf_addr`.
  - `rd_hit_mask`←hit ? `buf_mask` : 0.
- Read data phase: `HRDATA` byte i = `rd_hit_mask[i]` ? `buf_data` byte i : `SRAMRDATA` byte i. The merge covers both a write deferred in the same cycle and an older pending write.
- A pending write that drains during the read data phase is harmless. `buf_data` is not overwritten, and the SRAM returns the pre-write value, which the merge corrects.

## Timing
- Zero wait states. Read latency is 1 cycle, address phase to `HRDATA`.
- A write reaches the SRAM at the end of its data phase, or at the first following cycle without `rd_req`.
- Reset values: all state 0, `SRAMCS`=0, `SRAMWEN`=0, `SRAMADDR`=0, `SRAMWDATA`=0, `HRDATA`=0 via a 0 mask and zero `SRAMRDATA`, `HREADYOUT`=1, `HRESP`=0.
- Reset asserted mid-operation drops `wph` and `buf_pend` asynchronously. A pending write is lost, which is acceptable because the bus is also reset.
- `HREADY`=0 from another slave masks the address phase. `wph` still completes the data phase, since this slave's `HREADYOUT` is always 1 and the earlier address phase was accepted.

## Structure
- Shared package `ahb_sram_pkg` holds:
  - `HTRANS` encodings (IDLE, BUSY, NONSEQ, SEQ)
  - `HSIZE` encodings
  - the byte-mask function `ahb_byte_mask(hsize, addr_lo)`
- Single module with no sub-module. The mask function is the only reusable logic, and it lives in the package.

## Test plan
- Word write 0xDEADBEEF to 0x10, idle, read 0x10: `SRAMWEN`=1111 in the data phase, and `HRDATA`=0xDEADBEEF one cycle after the read address phase.
- Byte write 0xAA to 0x13, then a back-to-back read of 0x10 with memory previously 0x11223344: the write is deferred (`buf_pend`=1), and `HRDATA`=0xAA223344.
- Write 0x20, read 0x24, read 0x28, then idle: the write is held through both reads and drains in the idle cycle with `SRAMADDR`=0x8. Read data is unmerged.
- Alternating W/R/W/R to different words: no dropped writes, and `wph & buf_pend` is never 1 (assertion). A final readback of all words matches.
- Half write 0xBEEF to 0x32, a read of 0x30 deferring it, then a read of 0x30 again: both reads return 0xBEEF in the upper half.
- Assert `HRESETn` low while `buf_pend`=1: `SRAMCS`/`SRAMWEN` go to 0 immediately, and no SRAM write occurs after release.

Source files
------------

// File: rtl/ahb_sram_bridge_pkg.sv
// ahb_sram_bridge shared types and helpers.
// AHB transfer/size encodings and the byte-lane mask function.
package ahb_sram_pkg;

  typedef enum logic [1:0] {
    HT_IDLE   = 2'b00,
    HT_BUSY   = 2'b01,
    HT_NONSEQ = 2'b10,
    HT_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HS_BYTE = 3'd0,
    HS_HALF = 3'd1,
    HS_WORD = 3'd2
  } hsize_e;

  // Misaligned low address bits are simply ignored.
  function automatic logic [3:0] ahb_byte_mask(
    input logic [2:0] hsize,
    input logic [1:0] addr_lo
  );
    logic [3:0] m;
    case (hsize)
      3'd0:    m = 4'b0001 << addr_lo;
      3'd1:    m = addr_lo[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ahb_sram_bridge_if.sv
// ahb_sram_bridge bus interface.
// AHB-Lite slave side plus the SRAM macro port.
interface ahb_sram_bridge_if #(
  parameter int AW = 16
);
  logic          HSEL;
  logic          HREADY;
  logic [1:0]    HTRANS;
  logic [2:0]    HSIZE;
  logic          HWRITE;
  logic [31:0]   HADDR;
  logic [31:0]   HWDATA;
  logic          HREADYOUT;
  logic          HRESP;
  logic [31:0]   HRDATA;
  logic [31:0]   SRAMRDATA;
  logic [AW-1:0] SRAMADDR;
  logic [31:0]   SRAMWDATA;
  logic [3:0]    SRAMWEN;
  logic          SRAMCS;

  modport slave (
    input  HSEL, HREADY, HTRANS, HSIZE,
    input  HWRITE, HADDR, HWDATA, SRAMRDATA,
    output HREADYOUT, HRESP, HRDATA,
    output SRAMADDR, SRAMWDATA, SRAMWEN, SRAMCS
  );

  modport master (
    output HSEL, HREADY, HTRANS, HSIZE,
    output HWRITE, HADDR, HWDATA, SRAMRDATA,
    input  HREADYOUT, HRESP, HRDATA,
    input  SRAMADDR, SRAMWDATA, SRAMWEN, SRAMCS
  );
endinterface

// File: rtl/ahb_sram_bridge.sv
// ahb_sram_bridge: zero-wait AHB-Lite to SRAM front-end.
// One-entry write buffer drains on idle port cycles; reads merge it.
module ahb_sram_bridge #(
  parameter int AW = 16
) (
  input logic          HCLK,
  input logic          HRESETn,
  ahb_sram_bridge_if.slave bus
);
  import ahb_sram_pkg::*;

  logic          trans_ok;
  logic          rd_req;
  logic          wr_req;
  logic [AW-1:0] haddr_w;
  logic [3:0]    hmask;
  logic          hit;

  logic          wph_q, wph_d;
  logic [AW-1:0] buf_addr_q, buf_addr_d;
  logic [3:0]    buf_mask_q, buf_mask_d;
  logic [31:0]   buf_data_q, buf_data_d;
  logic          buf_pend_q, buf_pend_d;
  logic [3:0]    rd_hit_mask_q, rd_hit_mask_d;
  logic [AW-1:0] sram_addr_q, sram_addr_d;
  logic [31:0]   sram_wdata_q, sram_wdata_d;

  logic          sram_cs;
  logic [3:0]    sram_wen;
  logic [31:0]   hrdata;

  logic          unused_ok;
  assign unused_ok = ^{bus.HADDR[31:AW+2], bus.HTRANS[0]};

  assign trans_ok = bus.HSEL & bus.HREADY & bus.HTRANS[1];
  assign rd_req   = trans_ok & ~bus.HWRITE;
  assign wr_req   = trans_ok & bus.HWRITE;
  assign haddr_w  = bus.HADDR[AW+1:2];
  assign hmask    = ahb_byte_mask(bus.HSIZE, bus.HADDR[1:0]);
  assign hit      = (wph_q | buf_pend_q) & (haddr_w == buf_addr_q);

  // SRAM port arbitration: read, live write, drain, then hold.
  always_comb begin
    wph_d         = wr_req;
    buf_addr_d    = buf_addr_q;
    buf_mask_d    = buf_mask_q;
    buf_data_d    = buf_data_q;
    buf_pend_d    = buf_pend_q;
    rd_hit_mask_d = (rd_req & hit) ? buf_mask_q : 4'b0000;
    sram_cs       = 1'b0;
    sram_wen      = 4'b0000;
    sram_addr_d   = sram_addr_q;
    sram_wdata_d  = sram_wdata_q;
    if (wr_req) begin
      buf_addr_d = haddr_w;
      buf_mask_d = hmask;
    end
    if (rd_req) begin
      sram_cs     = 1'b1;
      sram_addr_d = haddr_w;
      if (wph_q) begin
        buf_data_d = bus.HWDATA;
        buf_pend_d = 1'b1;
      end
    end else if (wph_q) begin
      sram_cs      = 1'b1;
      sram_wen     = buf_mask_q;
      sram_addr_d  = buf_addr_q;
      sram_wdata_d = bus.HWDATA;
    end else if (buf_pend_q) begin
      sram_cs      = 1'b1;
      sram_wen     = buf_mask_q;
      sram_addr_d  = buf_addr_q;
      sram_wdata_d = buf_data_q;
      buf_pend_d   = 1'b0;
    end
  end

  // Read data: buffered bytes override stale SRAM bytes.
  always_comb begin
    hrdata = bus.SRAMRDATA;
    for (int i = 0; i < 4; i++) begin
      if (rd_hit_mask_q[i]) hrdata[8*i +: 8] = buf_data_q[8*i +: 8];
    end
  end

  // Bridge state and SRAM address/data hold registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wph_q         <= 1'b0;
      buf_addr_q    <= '0;
      buf_mask_q    <= 4'b0000;
      buf_data_q    <= 32'h0;
      buf_pend_q    <= 1'b0;
      rd_hit_mask_q <= 4'b0000;
      sram_addr_q   <= '0;
      sram_wdata_q  <= 32'h0;
    end else begin
      wph_q         <= wph_d;
      buf_addr_q    <= buf_addr_d;
      buf_mask_q    <= buf_mask_d;
      buf_data_q    <= buf_data_d;
      buf_pend_q    <= buf_pend_d;
      rd_hit_mask_q <= rd_hit_mask_d;
      sram_addr_q   <= sram_addr_d;
      sram_wdata_q  <= sram_wdata_d;
    end
  end

  assign bus.HREADYOUT = 1'b1;
  assign bus.HRESP     = 1'b0;
  assign bus.HRDATA    = hrdata;
  assign bus.SRAMCS    = sram_cs;
  assign bus.SRAMWEN   = sram_wen;
  assign bus.SRAMADDR  = sram_addr_d;
  assign bus.SRAMWDATA = sram_wdata_d;

endmodule

// File: tb/tb_ahb_sram_bridge.sv
// tb_ahb_sram_bridge: scoreboard bench for ahb_sram_bridge.
// Reference memory predicts read data; SRAM macro is modelled here.
module tb_ahb_sram_bridge;
  import ahb_sram_pkg::*;

  localparam int AW = 16;
  localparam int K_IDLE = 0;
  localparam int K_RD = 1;
  localparam int K_WR = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ahb_sram_bridge_if #(.AW(AW)) bus ();

  ahb_sram_bridge #(.AW(AW)) dut (
    .HCLK    (clk),
    .HRESETn (rst_n),
    .bus     (bus)
  );

  bit [31:0] smem [0:(1<<AW)-1];
  bit [31:0] rmem [0:(1<<AW)-1];
  bit [31:0] srd;
  logic [31:0] exp_q [$];

  int n_tot = 0;
  int n_bad = 0;
  logic inv_en = 1'b0;
  logic rd_dph;

  logic          wp_v = 1'b0;
  logic [AW-1:0] wp_a;
  logic [3:0]    wp_m;
  logic [31:0]   wp_d;

  assign bus.SRAMRDATA = srd;

  // SRAM macro: byte-enabled write, registered read.
  always @(posedge clk) begin
    if (bus.SRAMCS) begin
      if (|bus.SRAMWEN) begin
        for (int i = 0; i < 4; i++)
          if (bus.SRAMWEN[i])
            smem[bus.SRAMADDR][8*i +: 8] <= bus.SRAMWDATA[8*i +: 8];
      end else begin
        srd <= smem[bus.SRAMADDR];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] tb_mask(input logic [2:0] sz,
                                         input logic [1:0] lo);
    if (sz == 3'd0) return 4'b0001 << lo;
    if (sz == 3'd1) return lo[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  // Track read data phases from the driven bus.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_dph <= 1'b0;
    else rd_dph <= bus.HSEL & bus.HREADY & bus.HTRANS[1] & ~bus.HWRITE;
  end

  // Pop and compare read data in each data phase.
  always @(negedge clk) begin
    if (rst_n && rd_dph) begin
      if (exp_q.size() == 0) chk("rd_q_size", 32'(exp_q.size()), 32'd1);
      else chk("rdata", bus.HRDATA, exp_q.pop_front());
    end
    if (inv_en)
      chk("wph_and_pend", {31'b0, dut.wph_q & dut.buf_pend_q}, 32'd0);
  end

  // One bus cycle: address phase of k, data phase of the prior write.
  task automatic cyc(input int k, input logic [31:0] a = 32'h0,
                     input logic [2:0] sz = HS_WORD,
                     input logic [31:0] d = 32'h0,
                     input logic rdy = 1'b1);
    @(posedge clk); #1;
    bus.HWDATA = wp_v ? wp_d : 32'h0;
    if (wp_v)
      for (int i = 0; i < 4; i++)
        if (wp_m[i]) rmem[wp_a][8*i +: 8] = wp_d[8*i +: 8];
    wp_v = 1'b0;
    bus.HSEL   = (k != K_IDLE);
    bus.HREADY = rdy;
    bus.HTRANS = (k != K_IDLE) ? HT_NONSEQ : HT_IDLE;
    bus.HWRITE = (k == K_WR);
    bus.HADDR  = a;
    bus.HSIZE  = sz;
    if (rdy && k == K_RD) exp_q.push_back(rmem[a[AW+1:2]]);
    if (rdy && k == K_WR) begin
      wp_v = 1'b1;
      wp_a = a[AW+1:2];
      wp_m = tb_mask(sz, a[1:0]);
      wp_d = d;
    end
    @(negedge clk);
  endtask

  initial begin
    bus.HSEL = 1'b0; bus.HREADY = 1'b1; bus.HTRANS = HT_IDLE;
    bus.HSIZE = HS_WORD; bus.HWRITE = 1'b0;
    bus.HADDR = 32'h0; bus.HWDATA = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cs", {31'b0, bus.SRAMCS}, 32'd0);
    chk("rst_wen", 32'(bus.SRAMWEN), 32'd0);
    chk("rst_addr", 32'(bus.SRAMADDR), 32'd0);
    chk("rst_wdata", bus.SRAMWDATA, 32'd0);
    chk("rst_hrdata", bus.HRDATA, 32'd0);
    chk("rst_readyout", {31'b0, bus.HREADYOUT}, 32'd1);
    chk("rst_resp", {31'b0, bus.HRESP}, 32'd0);
    rst_n = 1'b1;

    // word write, idle, read back
    cyc(K_WR, 32'h10, HS_WORD, 32'hDEADBEEF);
    cyc(K_IDLE);
    chk("w1_wen", 32'(bus.SRAMWEN), 32'hF);
    chk("w1_addr", 32'(bus.SRAMADDR), 32'h4);
    chk("w1_wdata", bus.SRAMWDATA, 32'hDEADBEEF);
    cyc(K_RD, 32'h10);
    cyc(K_IDLE);

    // byte write deferred by back-to-back read
    cyc(K_WR, 32'h10, HS_WORD, 32'h11223344);
    cyc(K_IDLE);
    cyc(K_WR, 32'h13, HS_BYTE, 32'hAA000000);
    cyc(K_RD, 32'h10);
    cyc(K_IDLE);
    chk("b_pend", {31'b0, dut.buf_pend_q}, 32'd1);

    // write held through two reads, drains on idle
    cyc(K_WR, 32'h20, HS_WORD, 32'hCAFEF00D);
    cyc(K_RD, 32'h24);
    cyc(K_RD, 32'h28);
    cyc(K_IDLE);
    chk("drain_cs", {31'b0, bus.SRAMCS}, 32'd1);
    chk("drain_addr", 32'(bus.SRAMADDR), 32'h8);
    chk("drain_wen", 32'(bus.SRAMWEN), 32'hF);
    chk("drain_wdata", bus.SRAMWDATA, 32'hCAFEF00D);
    cyc(K_RD, 32'h20);
    cyc(K_IDLE);

    // alternating writes and reads, then readback
    inv_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc(K_WR, 32'h100 + 32'(8*i), HS_WORD, $urandom);
      cyc(K_RD, 32'h104 + 32'(8*i));
    end
    for (int i = 0; i < 8; i++) cyc(K_RD, 32'h100 + 32'(8*i));
    cyc(K_IDLE);
    inv_en = 1'b0;

    // half write, two reads of the same word
    cyc(K_WR, 32'h32, HS_HALF, 32'hBEEF0000);
    cyc(K_RD, 32'h30);
    cyc(K_RD, 32'h30);
    cyc(K_IDLE);

    // HREADY low masks address phase but not a write data phase
    cyc(K_WR, 32'h40, HS_WORD, 32'h12345678);
    cyc(K_RD, 32'h40, HS_WORD, 32'h0, 1'b0);
    chk("hrdy_cs", {31'b0, bus.SRAMCS}, 32'd1);
    chk("hrdy_wen", 32'(bus.SRAMWEN), 32'hF);
    chk("hrdy_addr", 32'(bus.SRAMADDR), 32'h10);
    cyc(K_RD, 32'h40);
    cyc(K_IDLE);

    // reset while a deferred write is pending
    cyc(K_WR, 32'h50, HS_WORD, 32'h55AA55AA);
    cyc(K_RD, 32'h54);
    @(posedge clk); #1;
    bus.HSEL = 1'b0; bus.HTRANS = HT_IDLE; bus.HWRITE = 1'b0;
    bus.HWDATA = 32'h0;
    rst_n = 1'b0;
    #1;
    chk("arst_cs", {31'b0, bus.SRAMCS}, 32'd0);
    chk("arst_wen", 32'(bus.SRAMWEN), 32'd0);
    chk("arst_pend", {31'b0, dut.buf_pend_q}, 32'd0);
    exp_q.delete();
    rmem[14'h14] = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) cyc(K_IDLE);
    chk("arst_nowr", smem[16'h14], 32'd0);
    cyc(K_RD, 32'h50);
    cyc(K_IDLE);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) cyc(K_IDLE);
    chk("q_drain", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
